// File: rtl/beatmap_note_reader.sv
// Beatmap byte FIFO plus beat-timed note decoder for the lane renderer/scorer.
// Optional stream sequence checker enabled by defining BEATMAP_SEQ_CHECK_EN.
module beatmap_note_reader #(
  parameter int DEPTH       = 8,
  parameter int BEAT_CYCLES = 16,
  parameter int SEQ_BASE    = 160,
  parameter int SEQ_LAST    = 176,
  parameter int SEQ_STEP    = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     start,
  input  logic                     stop,
  output logic                     beat_tick,
  output logic                     note_valid,
  output logic [3:0]               note_lane,
  output logic                     note_hold,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               underrun_cnt,
  output logic                     busy,
  output logic                     seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BEAT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BEAT_CYCLES < 2 ||
      SEQ_STEP < 1 || SEQ_BASE > 255 || SEQ_LAST > 255) begin : g_bad_param
    $error("beatmap_note_reader: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q;
  logic [7:0]      mem_q [DEPTH];
  logic            beat_tick_q, note_valid_q, note_hold_q;
  logic [3:0]      note_lane_q;
  logic [7:0]      underrun_q;

  logic       full, empty, tick, push, pop, head_is_note, head_unused;
  logic [7:0] head;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign tick     = (state_q != S_IDLE) && (cnt_q == CNT_LAST);
  assign in_ready = !full && (state_q != S_DRAIN);
  assign push     = in_valid && in_ready;
  assign pop      = tick && !empty;

  assign head         = mem_q[rd_ptr_q];
  assign head_is_note = (head[7:4] == 4'hA) || (head[7:4] == 4'hB);
  assign head_unused  = ^head[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Beat counter free-runs in PLAY/DRAIN; stop outranks start.
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && !stop) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tick && empty) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      beat_tick_q  <= 1'b0;
      note_valid_q <= 1'b0;
      note_lane_q  <= '0;
      note_hold_q  <= 1'b0;
      underrun_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      beat_tick_q  <= tick;
      note_valid_q <= pop && head_is_note;
      // Lane/hold only move on real notes so they stay tied to the last note_valid.
      if (pop && head_is_note) begin
        note_lane_q <= 4'b0001 << head[3:2];
        note_hold_q <= (head[7:4] == 4'hB);
      end
      if (tick && empty && state_q == S_PLAY && underrun_q != 8'hFF)
        underrun_q <= underrun_q + 1'b1;
    end
  end

  assign beat_tick    = beat_tick_q;
  assign note_valid   = note_valid_q;
  assign note_lane    = note_lane_q;
  assign note_hold    = note_hold_q;
  assign fifo_level   = level_q;
  assign underrun_cnt = underrun_q;
  assign busy         = (state_q != S_IDLE);

`ifdef BEATMAP_SEQ_CHECK_EN
  logic [7:0] seq_exp_q;
  logic       seq_err_q;

  // Expected value always follows the received byte, so one bad byte flags once and re-syncs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_exp_q <= 8'(SEQ_BASE);
      seq_err_q <= 1'b0;
    end else if (push) begin
      if (in_data != seq_exp_q) seq_err_q <= 1'b1;
      seq_exp_q <= (in_data == 8'(SEQ_LAST)) ? 8'(SEQ_BASE) : in_data + 8'(SEQ_STEP);
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_beatmap_note_reader.sv
// Directed bench for beatmap_note_reader; checks follow BEATMAP_SEQ_CHECK_EN when defined.
module tb_beatmap_note_reader;

  logic       clk, resetn, in_valid, in_ready, start, stop;
  logic [7:0] in_data;
  logic       beat_tick, note_valid, note_hold, busy, seq_err;
  logic [3:0] note_lane, fifo_level;
  logic [7:0] underrun_cnt;

  int vecs = 0;
  int errs = 0;

  beatmap_note_reader dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .start(start), .stop(stop), .beat_tick(beat_tick),
    .note_valid(note_valid), .note_lane(note_lane), .note_hold(note_hold),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt), .busy(busy),
    .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  // Steps negedges until beat_tick is seen (bounded) and checks the distance.
  task automatic tick_wait(input int exp_n, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (beat_tick !== 1'b1 && n < 64);
    chk(tag, n, exp_n);
  endtask

  logic exp_seq;

  initial begin
    // reset state
    do_reset();
    chk("rst_ready", in_ready, 1);
    chk("rst_tick", beat_tick, 0);
    chk("rst_nv", note_valid, 0);
    chk("rst_lane", note_lane, 0);
    chk("rst_hold", note_hold, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_under", underrun_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq", seq_err, 0);

    // 1: five notes then drain to idle
    for (int i = 0; i < 5; i++) push_byte(8'(160 + 4 * i));
    chk("t1_level", fifo_level, 5);
    chk("t1_seq", seq_err, 0);
    pulse_start();
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      tick_wait(16, "t1_tick_dist");
      chk("t1_nv", note_valid, 1);
      chk("t1_lane", note_lane, 32'(4'b0001 << (i % 4)));
      chk("t1_hold", note_hold, (i == 4) ? 1 : 0);
      chk("t1_level_dec", fifo_level, 32'(4 - i));
    end
    @(negedge clk);
    chk("t1_nv_pulse", note_valid, 0);
    chk("t1_tick_pulse", beat_tick, 0);
    pulse_stop();
    chk("t1_drain_ready", in_ready, 0);
    tick_wait(14, "t1_drain_tick");
    chk("t1_idle", busy, 0);
    chk("t1_drain_nv", note_valid, 0);
    chk("t1_drain_under", underrun_cnt, 0);

    // 4: stop with 3 bytes queued
    do_reset();
    push_byte(8'hA0); push_byte(8'hA4); push_byte(8'hA8);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_stop();
    chk("t4_ready", in_ready, 0);
    chk("t4_busy", busy, 1);
    push_byte(8'hAC);
    chk("t4_drop", fifo_level, 3);
    tick_wait(11, "t4_tick1");
    chk("t4_lane1", note_lane, 4'b0001);
    chk("t4_level1", fifo_level, 2);
    tick_wait(16, "t4_tick2");
    chk("t4_lane2", note_lane, 4'b0010);
    tick_wait(16, "t4_tick3");
    chk("t4_lane3", note_lane, 4'b0100);
    chk("t4_nv3", note_valid, 1);
    chk("t4_level3", fifo_level, 0);
    tick_wait(16, "t4_tick4");
    chk("t4_idle", busy, 0);
    chk("t4_nv4", note_valid, 0);
    chk("t4_under", underrun_cnt, 0);
    chk("t4_ready_back", in_ready, 1);

    // 5: start&&stop in IDLE, then a non-note byte
    do_reset();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t5_both_idle", busy, 0);
    push_byte(8'h50); push_byte(8'hA4);
    pulse_start();
    tick_wait(16, "t5_tick1");
    chk("t5_junk_nv", note_valid, 0);
    chk("t5_junk_level", fifo_level, 1);
    chk("t5_junk_under", underrun_cnt, 0);
    tick_wait(16, "t5_tick2");
    chk("t5_nv", note_valid, 1);
    chk("t5_lane", note_lane, 4'b0010);
    chk("t5_level", fifo_level, 0);

    // 3: overfill, then push/pop interplay
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk("t3_ready_fill", in_ready, (i < 8) ? 1 : 0);
      in_valid = 1'b1; in_data = 8'(160 + 4 * (i % 5));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t3_full_level", fifo_level, 8);
    chk("t3_full_ready", in_ready, 0);
    pulse_start();
    tick_wait(16, "t3_tick1");
    chk("t3_lane1", note_lane, 4'b0001);
    chk("t3_level1", fifo_level, 7);
    repeat (15) @(negedge clk);
    in_valid = 1'b1; in_data = 8'hB0;
    @(negedge clk);
    chk("t3_tick2", beat_tick, 1);
    chk("t3_pushpop_level", fifo_level, 7);
    chk("t3_lane2", note_lane, 4'b0010);
    @(negedge clk);
    chk("t3_refill", fifo_level, 8);
    chk("t3_refill_ready", in_ready, 0);
    repeat (15) @(negedge clk);
    chk("t3_tick3", beat_tick, 1);
    chk("t3_fullpop_level", fifo_level, 7);
    chk("t3_lane3", note_lane, 4'b0100);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_refill2", fifo_level, 8);

    // 2: underruns, saturation, then async reset mid-PLAY
    do_reset();
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      tick_wait(16, "t2_tick");
      chk("t2_nv", note_valid, 0);
      chk("t2_under", underrun_cnt, 32'(k));
    end
    repeat (300 * 16) @(negedge clk);
    chk("t2_sat", underrun_cnt, 255);
    chk("t2_busy", busy, 1);
    #3 resetn = 1'b0;
    #1;
    chk("t6_rst_under", underrun_cnt, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_lane", note_lane, 0);
    chk("t6_rst_ready", in_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // 6: sequence checker
`ifdef BEATMAP_SEQ_CHECK_EN
    exp_seq = 1'b1;
`else
    exp_seq = 1'b0;
`endif
    push_byte(8'd160);
    chk("t6_seq_a", seq_err, 0);
    push_byte(8'd164);
    chk("t6_seq_b", seq_err, 0);
    push_byte(8'd172);
    chk("t6_seq_bad", seq_err, 32'(exp_seq));
    push_byte(8'd176);
    chk("t6_seq_sticky", seq_err, 32'(exp_seq));
    chk("t6_level", fifo_level, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
